// File: rtl/bist_pattern_driver_pkg.sv
// Shared types and polynomial helpers for the BIST pattern driver.
// LFSR is x^8+x^6+x^5+x^4+1 (Fibonacci), MISR is x^6+x+1 (Galois).
package bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_t;

   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
   // Feedback from sig[5] folds into bits 0 and 1 (the x and 1 terms).
   localparam logic [5:0] MISR_TAPS = 6'b00_0011;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [5:0] misr_next(input logic [5:0] s, input logic [5:0] r);
      return {s[4:0], 1'b0} ^ ({6{s[5]}} & MISR_TAPS) ^ r;
   endfunction

endpackage

// File: rtl/bist_pattern_driver_if.sv
// Control, status and DUT-facing signals of the BIST pattern driver.
interface bist_pattern_driver_if #(
   parameter int STIM_W = 8,
   parameter int RESP_W = 6,
   parameter int CNT_W  = 16
);
   // start is a level request honoured only in IDLE/DONE (no ready side);
   // abort is a level that wins over everything; busy/done/pass are status levels.
   logic              start;
   logic              abort;
   logic [CNT_W-1:0]  num_patterns;
   logic [RESP_W-1:0] golden;
   logic [STIM_W-1:0] stim;
   logic [RESP_W-1:0] resp;
   logic              busy;
   logic              done;
   logic [RESP_W-1:0] signature;
   logic              pass;

   modport master (
      output start, abort, num_patterns, golden, resp,
      input  stim, busy, done, signature, pass
   );

   modport slave (
      input  start, abort, num_patterns, golden, resp,
      output stim, busy, done, signature, pass
   );
endinterface

// File: rtl/bist_pattern_driver_misr.sv
// Signature register with seed load and capture enable.
// BIST_RESP_REG_EN inserts a response register and delays the capture enable by one cycle.
module bist_misr
   import bist_pkg::*;
#(
   parameter int                RESP_W    = 6,
   parameter logic [RESP_W-1:0] MISR_SEED = 6'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              cap_i,
   input  logic              abort_i,
   input  logic [RESP_W-1:0] resp_i,
   output logic [RESP_W-1:0] sig_o
);

   logic [RESP_W-1:0] sig_q;
   logic [RESP_W-1:0] data;
   logic              en;

`ifdef BIST_RESP_REG_EN
   logic [RESP_W-1:0] resp_q;
   logic              en_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_q <= '0;
         en_q   <= 1'b0;
      end else begin
         resp_q <= resp_i;
         en_q   <= cap_i;
      end
   end

   assign data = resp_q;
   assign en   = en_q && !abort_i;
`else
   assign data = resp_i;
   assign en   = cap_i && !abort_i;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= MISR_SEED;
      end else if (load_i) begin
         sig_q <= MISR_SEED;
      end else if (en) begin
         sig_q <= misr_next(sig_q, data);
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/bist_pattern_driver.sv
// LFSR stimulus / MISR response harness for flat logic clouds.
// BIST_RESP_REG_EN selects the registered-response variant (adds the FLUSH cycle).
module bist_pattern_driver
   import bist_pkg::*;
#(
   parameter int                STIM_W    = 8,
   parameter int                RESP_W    = 6,
   parameter int                CNT_W     = 16,
   parameter logic [STIM_W-1:0] LFSR_SEED = 8'hA5,
   parameter logic [RESP_W-1:0] MISR_SEED = 6'h00
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bist_pattern_driver_if.slave bus,
   output bist_state_t          state_o
);

   // An all-zero seed would lock the LFSR.
   localparam logic [STIM_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? STIM_W'(1) : LFSR_SEED;

   bist_state_t       state_q, state_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [STIM_W-1:0] lfsr_q, lfsr_d;
   logic [RESP_W-1:0] sig;
   logic              load;
   logic              cap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         lfsr_q  <= SEED_EFF;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         lfsr_q  <= lfsr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      lfsr_d  = lfsr_q;
      load    = 1'b0;
      cap     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               load    = 1'b1;
               rem_d   = bus.num_patterns;
               lfsr_d  = SEED_EFF;
               state_d = (bus.num_patterns == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            cap    = 1'b1;
            lfsr_d = lfsr_next(lfsr_q);
            rem_d  = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
`ifdef BIST_RESP_REG_EN
               state_d = ST_FLUSH;
`else
               state_d = ST_DONE;
`endif
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
      // Abort freezes stimulus, count and signature where they are.
      if (bus.abort) begin
         state_d = ST_IDLE;
         rem_d   = rem_q;
         lfsr_d  = lfsr_q;
         load    = 1'b0;
         cap     = 1'b0;
      end
   end

   bist_misr #(
      .RESP_W    (RESP_W),
      .MISR_SEED (MISR_SEED)
   ) u_misr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .cap_i   (cap),
      .abort_i (bus.abort),
      .resp_i  (bus.resp),
      .sig_o   (sig)
   );

   assign bus.stim      = lfsr_q;
   assign bus.signature = sig;
   assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.pass      = (state_q == ST_DONE) && (sig == bus.golden);
   assign state_o       = state_q;

endmodule

// File: tb/tb_bist_pattern_driver.sv
// Directed bench for bist_pattern_driver: stimulus sequence, signatures, latency, abort, reset.
module tb_bist_pattern_driver;
   import bist_pkg::*;

`ifdef BIST_RESP_REG_EN
   localparam int XL = 1;
`else
   localparam int XL = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   bist_state_t state;
   int          total = 0;
   int          bad = 0;
   int          lat;

   bist_pattern_driver_if bus ();

   bist_pattern_driver dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .state_o (state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps until done (bounded); lat counts cycles since the start edge.
   task automatic wait_done(input int lat_in, output int lat_out);
      lat_out = lat_in;
      while (!bus.done && lat_out < 200) begin
         step();
         lat_out++;
      end
   endtask

   task automatic start_run(input logic [15:0] n);
      bus.num_patterns = n;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.num_patterns = '0;
      bus.golden       = '0;
      bus.resp         = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_stim", 32'(bus.stim), 32'hA5);
      chk("rst_sig", 32'(bus.signature), 32'h00);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_pass", 32'(bus.pass), 0);
      chk("rst_state", 32'(state), 32'(ST_IDLE));
      step();
      step();
      rst_n = 1'b1;
      step();

      // N=3, resp 0: stimulus sequence and latency
      start_run(16'd3);
      chk("n3_busy", 32'(bus.busy), 1);
      chk("n3_stim0", 32'(bus.stim), 32'hA5);
      step();
      chk("n3_stim1", 32'(bus.stim), 32'h4A);
      step();
      chk("n3_stim2", 32'(bus.stim), 32'h95);
      wait_done(3, lat);
      chk("n3_lat", 32'(lat), 32'(4 + XL));
      chk("n3_sig", 32'(bus.signature), 32'h00);
      chk("n3_pass", 32'(bus.pass), 1);
      chk("n3_busy_done", 32'(bus.busy), 0);
      chk("n3_stim_end", 32'(bus.stim), 32'h2A);
      step();
      chk("n3_done_hold", 32'(bus.done), 1);

      // N=1 and N=2 with resp 01
      bus.resp = 6'h01;
      start_run(16'd1);
      wait_done(1, lat);
      chk("n1_lat", 32'(lat), 32'(2 + XL));
      chk("n1_sig", 32'(bus.signature), 32'h01);
      start_run(16'd2);
      wait_done(1, lat);
      chk("n2_lat", 32'(lat), 32'(3 + XL));
      chk("n2_sig", 32'(bus.signature), 32'h03);

      // N=3, resp 2A exercises the sig[5] feedback path
      bus.resp   = 6'h2A;
      bus.golden = 6'h13;
      start_run(16'd3);
      wait_done(1, lat);
      chk("r2a_sig", 32'(bus.signature), 32'h13);
      chk("r2a_pass", 32'(bus.pass), 1);
      bus.golden = 6'h12;
      #1;
      chk("r2a_pass_bad_golden", 32'(bus.pass), 0);

      // N=0 goes straight to DONE and reloads the seed
      bus.golden = 6'h00;
      start_run(16'd0);
      chk("n0_done", 32'(bus.done), 1);
      chk("n0_busy", 32'(bus.busy), 0);
      chk("n0_sig", 32'(bus.signature), 32'h00);
      chk("n0_pass", 32'(bus.pass), 1);
      chk("n0_stim", 32'(bus.stim), 32'hA5);

      // abort mid-run, with start held alongside
      bus.resp = 6'h01;
      start_run(16'd10);
      step();
      step();
      step();
      bus.abort = 1'b1;
      bus.start = 1'b1;
      step();
      chk("ab_state", 32'(state), 32'(ST_IDLE));
      chk("ab_busy", 32'(bus.busy), 0);
      chk("ab_done", 32'(bus.done), 0);
      chk("ab_sig", 32'(bus.signature), (XL == 1) ? 32'h03 : 32'h07);
      chk("ab_stim", 32'(bus.stim), 32'h2A);
      step();
      chk("ab_start_ignored", 32'(state), 32'(ST_IDLE));
      chk("ab_sig_frozen", 32'(bus.signature), (XL == 1) ? 32'h03 : 32'h07);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      step();

      // asynchronous reset mid-run
      start_run(16'd5);
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_stim", 32'(bus.stim), 32'hA5);
      chk("arst_sig", 32'(bus.signature), 32'h00);
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_state", 32'(state), 32'(ST_IDLE));
      step();
      rst_n = 1'b1;
      bus.resp = 6'h00;
      start_run(16'd3);
      chk("rerun_stim0", 32'(bus.stim), 32'hA5);
      step();
      chk("rerun_stim1", 32'(bus.stim), 32'h4A);
      step();
      chk("rerun_stim2", 32'(bus.stim), 32'h95);
      wait_done(3, lat);
      chk("rerun_lat", 32'(lat), 32'(4 + XL));

      // back-to-back: start held through DONE, changes while busy ignored
      bus.resp         = 6'h01;
      bus.num_patterns = 16'd2;
      bus.start        = 1'b1;
      step();
      wait_done(1, lat);
      chk("b2b_lat1", 32'(lat), 32'(3 + XL));
      step();
      chk("b2b_restart_busy", 32'(bus.busy), 1);
      chk("b2b_restart_done", 32'(bus.done), 0);
      chk("b2b_restart_stim", 32'(bus.stim), 32'hA5);
      bus.num_patterns = 16'd7;
      wait_done(1, lat);
      chk("b2b_lat2", 32'(lat), 32'(3 + XL));
      chk("b2b_sig", 32'(bus.signature), 32'h03);
      bus.start = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bist_pattern_driver.md
# bist_pattern_driver

Sequential stimulus/response harness for the team's flat standard-cell logic clouds. It drives an LFSR pattern onto a DUT's 8 primary inputs and compacts the DUT's 6 primary outputs into a MISR signature. It then compares that signature against a golden value. The block sits on the opposite side of the DUT's ports: it produces what the cloud consumes and consumes what it produces, so each netlist can be exercised on silicon and after clock-tree insertion.

## Interface
- `STIM_W`, 8: stimulus width; the LFSR polynomial is fixed for 8.
- `RESP_W`, 6: response/signature width; the MISR polynomial is fixed for 6.
- `CNT_W`, 16: pattern counter width.
- `LFSR_SEED`, 8'hA5: stimulus seed; 0 is illegal and is replaced by 8'h01.
- `MISR_SEED`, 6'h00: signature seed.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `start`  in  1  start request; level-sampled in IDLE/DONE.
- `abort`  in  1  return to IDLE without done.
- `num_patterns`  in  CNT_W  pattern count, latched on start.
- `golden`  in  RESP_W  expected signature, compared in DONE.
- `stim`  out  STIM_W  DUT stimulus, registered.
- `resp`  in  RESP_W  DUT response, combinational from stim.
- `busy`  out  1  high in RUN/FLUSH.
- `done`  out  1  high in DONE until next start/abort.
- `signature`  out  RESP_W  MISR contents.
- `pass`  out  1  done && signature==golden.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE + start:
  - latch num_patterns into `remaining`;
  - load LFSR with seed and MISR with MISR_SEED;
  - go to RUN, or straight to DONE if num_patterns==0.
- RUN, each cycle:
  - capture resp into MISR;
  - advance LFSR;
  - decrement remaining;
  - at remaining==1, go to FLUSH (register config) or DONE.
- FLUSH: one cycle to capture the final registered resp, then DONE.
- LFSR (Fibonacci, x^8+x^6+x^5+x^4+1): next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- MISR (Galois, x^6+x+1), with fb=sig[5]:
  - next[0]=fb^r[0];
  - next[1]=sig[0]^fb^r[1];
  - next[i]=sig[i-1]^r[i] for i=2..5.
- stim = lfsr.
- In IDLE/DONE, stim holds its last value; after reset it is LFSR_SEED.
- start while busy: ignored.
- abort has priority over start and over every transition: next state IDLE, signature frozen, done=0.
- Simultaneous abort+start in IDLE: stay IDLE.
- remaining wraps never: exactly N captures for N≥1; N=2^CNT_W−1 is supported.

## Timing
- Reset values:
  - stim=LFSR_SEED;
  - signature=MISR_SEED;
  - busy=0, done=0, pass=0;
  - state IDLE.
- Reset mid-run discards all progress.
- start sampled at edge T → busy and first pattern at T+1.
- Without register: pattern k is applied in cycle T+1+k and captured at the end of the same cycle. done rises at T+1+N, so latency = N+1 cycles.
- With register: capture is one cycle after apply. done rises at T+2+N.
- done/pass are registered and valid the same cycle.
- golden must be stable while done=1.

## Configuration
- `BIST_RESP_REG_EN` defined:
  - resp passes through an RESP_W-bit register (reset 0) before the MISR;
  - the FLUSH state is used;
  - the register's first RUN-cycle contents are not compacted, because the MISR enable is delayed one cycle.
- Undefined:
  - resp feeds the MISR directly;
  - FLUSH is unreachable;
  - done arrives one cycle earlier.

## Structure
- Package `bist_pkg`:
  - state enum `bist_state_t`;
  - LFSR/MISR tap constants;
  - `lfsr_next`/`misr_next` functions.
- Natural sub-module `bist_misr`: signature register with enable, seed load and optional input register.
- The FSM, counter and LFSR stay in the top module.

## Test plan
- Seed A5, N=3, resp tied 0 → stim sequence A5, 4A, 95; signature 00; done at T+4 (T+5 with register).
- N=1, resp=6'h01 constant, MISR_SEED 0 → signature 01. N=2 → signature 03.
- N=0 → done at T+1, busy never high, signature = MISR_SEED; golden=MISR_SEED → pass=1.
- abort asserted mid-RUN (N=10, after 4 cycles) → IDLE next cycle, done=0, start ignored while abort=1.
- rst_n pulsed low mid-RUN → all outputs at reset values asynchronously; a fresh start reproduces the reference stim sequence.
- Back-to-back: start held high through DONE → new run begins the cycle after done; start during busy has no effect on count.
